// File: rtl/exec_pkg.sv
// Shared opcode, FSM-state and width definitions for the execute/writeback stage.
package exec_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 4;

  typedef enum logic [3:0] {
    OpAdd   = 4'd0,
    OpSub   = 4'd1,
    OpAnd   = 4'd2,
    OpOr    = 4'd3,
    OpXor   = 4'd4,
    OpNor   = 4'd5,
    OpSlt   = 4'd6,
    OpSll   = 4'd7,
    OpSrl   = 4'd8,
    OpPassb = 4'd9,
    OpMul   = 4'd10
  } alu_op_e;

  typedef enum logic {
    StIdle,
    StMulBusy
  } state_e;

endpackage

// File: rtl/alu_comb.sv
// Combinational single-cycle ALU; multiply is handled iteratively by the parent stage.
module alu_comb
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              carry_upd,
  output logic              op_valid
);

  localparam int unsigned SHIFT_W = $clog2(DATA_W);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Top bit of the widened difference is the unsigned borrow.
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result    = '0;
    carry     = 1'b0;
    carry_upd = 1'b0;
    op_valid  = 1'b1;
    case (alu_op_e'(alu_op))
      OpAdd: begin
        result    = sum[DATA_W-1:0];
        carry     = sum[DATA_W];
        carry_upd = 1'b1;
      end
      OpSub: begin
        result    = diff[DATA_W-1:0];
        carry     = diff[DATA_W];
        carry_upd = 1'b1;
      end
      OpAnd:   result = a & b;
      OpOr:    result = a | b;
      OpXor:   result = a ^ b;
      OpNor:   result = ~(a | b);
      OpSlt:   result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OpSll:   result = a << b[SHIFT_W-1:0];
      OpSrl:   result = a >> b[SHIFT_W-1:0];
      OpPassb: result = b;
      default: op_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_writeback_stage.sv
// Execute stage: single-cycle ALU ops, iterative shift-add multiply, registered
// register-file write port and zero/carry flags.
module execute_writeback_stage
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned MUL_CYCLES = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] reg_read_data_1,
  input  logic [DATA_W-1:0] reg_read_data_2,
  input  logic [DATA_W-1:0] imm,
  input  logic              use_imm,
  input  logic              wb_en_in,
  input  logic [ADDR_W-1:0] wb_dest_in,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] reg_write_dest,
  output logic [DATA_W-1:0] reg_write_data,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  state_e state_q, state_d;
  logic [DATA_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, prod_q, prod_d, prod_next;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mdest_q, mdest_d, wdest_q, wdest_d;
  logic              mwb_q, mwb_d, we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              zero_q, zero_d, carry_q, carry_d;

  logic [DATA_W-1:0] op_b, alu_result;
  logic              alu_carry, alu_carry_upd, alu_op_valid;

  assign op_b = use_imm ? imm : reg_read_data_2;

  alu_comb #(
    .DATA_W(DATA_W)
  ) u_alu (
    .alu_op   (alu_op),
    .a        (reg_read_data_1),
    .b        (op_b),
    .result   (alu_result),
    .carry    (alu_carry),
    .carry_upd(alu_carry_upd),
    .op_valid (alu_op_valid)
  );

  always_comb begin
    state_d   = state_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    mdest_d   = mdest_q;
    mwb_d     = mwb_q;
    we_d      = 1'b0;
    wdest_d   = wdest_q;
    wdata_d   = wdata_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    prod_next = prod_q + (mul_b_q[0] ? mul_a_q : '0);
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (alu_op_e'(alu_op) == OpMul) begin
            mul_a_d = reg_read_data_1;
            mul_b_d = op_b;
            mdest_d = wb_dest_in;
            mwb_d   = wb_en_in;
            prod_d  = '0;
            cnt_d   = '0;
            state_d = StMulBusy;
          end else begin
            wdata_d = alu_result;
            wdest_d = wb_dest_in;
            we_d    = wb_en_in && (wb_dest_in != '0) && alu_op_valid;
            zero_d  = (alu_result == '0);
            if (alu_carry_upd) carry_d = alu_carry;
          end
        end
      end
      StMulBusy: begin
        prod_d  = prod_next;
        mul_a_d = mul_a_q << 1;
        mul_b_d = mul_b_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        // Final iteration retires straight onto the write port.
        if (cnt_q == CNT_LAST) begin
          state_d = StIdle;
          wdata_d = prod_next;
          wdest_d = mdest_q;
          we_d    = mwb_q && (mdest_q != '0);
          zero_d  = (prod_next == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mul_a_q <= '0;
      mul_b_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      mdest_q <= '0;
      mwb_q   <= 1'b0;
      we_q    <= 1'b0;
      wdest_q <= '0;
      wdata_q <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      mdest_q <= mdest_d;
      mwb_q   <= mwb_d;
      we_q    <= we_d;
      wdest_q <= wdest_d;
      wdata_q <= wdata_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign in_ready       = (state_q == StIdle);
  assign busy           = (state_q == StMulBusy);
  assign reg_write_en   = we_q;
  assign reg_write_dest = wdest_q;
  assign reg_write_data = wdata_q;
  assign zero_flag      = zero_q;
  assign carry_flag     = carry_q;

endmodule

// File: tb/tb_execute_writeback_stage.sv
// Directed bench for execute_writeback_stage with a cycle-level reference model.
module tb_execute_writeback_stage;

  localparam int OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR = 3, OP_XOR = 4, OP_NOR = 5;
  localparam int OP_SLT = 6, OP_SLL = 7, OP_SRL = 8, OP_PASSB = 9, OP_MUL = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] alu_op = '0;
  logic [7:0] reg_read_data_1 = '0, reg_read_data_2 = '0, imm = '0;
  logic       use_imm = 1'b0, wb_en_in = 1'b0;
  logic [3:0] wb_dest_in = '0;
  logic       reg_write_en;
  logic [3:0] reg_write_dest;
  logic [7:0] reg_write_data;
  logic       zero_flag, carry_flag, busy;

  execute_writeback_stage dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_op         (alu_op),
    .reg_read_data_1(reg_read_data_1),
    .reg_read_data_2(reg_read_data_2),
    .imm            (imm),
    .use_imm        (use_imm),
    .wb_en_in       (wb_en_in),
    .wb_dest_in     (wb_dest_in),
    .reg_write_en   (reg_write_en),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data),
    .zero_flag      (zero_flag),
    .carry_flag     (carry_flag),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Simple register file fed by the write port, for the end-to-end check.
  logic [7:0] rf [16];
  always @(posedge clk) if (reg_write_en) rf[reg_write_dest] <= reg_write_data;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: expected outputs for the current cycle.
  int e_we, e_dest, e_data, e_zero, e_carry, e_busy, e_ready;
  int busy_left, pm_data, pm_dest, pm_wb;
  bit model_reset = 1'b0;

  function automatic void alu_model(input int op, input int a, input int b, output int res,
                                    output int cy, output bit upd, output bit ok);
    int sa, sb;
    res = 0; cy = 0; upd = 1'b0; ok = 1'b1;
    sa  = (a >= 128) ? a - 256 : a;
    sb  = (b >= 128) ? b - 256 : b;
    case (op)
      OP_ADD:   begin res = (a + b) % 256; cy = (a + b > 255) ? 1 : 0; upd = 1'b1; end
      OP_SUB:   begin res = (a - b + 256) % 256; cy = (a < b) ? 1 : 0; upd = 1'b1; end
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_NOR:   res = 255 - (a | b);
      OP_SLT:   res = (sa < sb) ? 1 : 0;
      OP_SLL:   res = (a << (b % 8)) % 256;
      OP_SRL:   res = a >> (b % 8);
      OP_PASSB: res = b;
      default:  ok = 1'b0;
    endcase
  endfunction

  task automatic model_clear();
    e_we = 0; e_dest = 0; e_data = 0; e_zero = 0; e_carry = 0; e_busy = 0; e_ready = 1;
    busy_left = 0;
  endtask

  // Advance the model across the coming clock edge using the inputs now on the bus.
  task automatic model_step();
    int a, b, res, cy;
    bit upd, ok;
    a = int'(reg_read_data_1);
    b = use_imm ? int'(imm) : int'(reg_read_data_2);
    e_we = 0;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        e_data = pm_data; e_dest = pm_dest; e_zero = (pm_data == 0) ? 1 : 0;
        e_we   = (pm_wb != 0 && pm_dest != 0) ? 1 : 0;
      end
    end else if (in_valid) begin
      if (int'(alu_op) == OP_MUL) begin
        pm_data = (a * b) % 256; pm_dest = int'(wb_dest_in); pm_wb = int'(wb_en_in);
        busy_left = 8;
      end else begin
        alu_model(int'(alu_op), a, b, res, cy, upd, ok);
        e_data = res; e_dest = int'(wb_dest_in); e_zero = (res == 0) ? 1 : 0;
        e_we   = (wb_en_in && wb_dest_in != 0 && ok) ? 1 : 0;
        if (upd) e_carry = cy;
      end
    end
    e_busy  = (busy_left > 0) ? 1 : 0;
    e_ready = (busy_left == 0) ? 1 : 0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(negedge clk);
      if (rst || model_reset) begin
        model_reset = 1'b0;
        model_clear();
      end
      chk("m_in_ready", int'(in_ready), e_ready);
      chk("m_busy", int'(busy), e_busy);
      chk("m_we", int'(reg_write_en), e_we);
      chk("m_dest", int'(reg_write_dest), e_dest);
      chk("m_data", int'(reg_write_data), e_data);
      chk("m_zero", int'(zero_flag), e_zero);
      chk("m_carry", int'(carry_flag), e_carry);
      if (!rst) model_step();
    end
  end

  // Present an instruction and hold it until it is accepted; returns 1 ns after the
  // accepting edge, i.e. in the cycle where a single-cycle result is visible.
  task automatic issue(input int op, input int a, input int b, input int im, input int ui,
                       input int wb, input int dest);
    logic rdy;
    alu_op = 4'(op); reg_read_data_1 = 8'(a); reg_read_data_2 = 8'(b); imm = 8'(im);
    use_imm = ui[0]; wb_en_in = wb[0]; wb_dest_in = 4'(dest); in_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) return;
    end
    chk("issue_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_we", int'(reg_write_en), 0);
    rst = 1'b0;
    idle(1);

    // ADD with carry-out
    issue(OP_ADD, 8'hF0, 8'h20, 0, 0, 1, 3);
    chk("add_we", int'(reg_write_en), 1);
    chk("add_dest", int'(reg_write_dest), 3);
    chk("add_data", int'(reg_write_data), 8'h10);
    chk("add_carry", int'(carry_flag), 1);
    chk("add_zero", int'(zero_flag), 0);
    idle(1);
    chk("hold_we", int'(reg_write_en), 0);
    chk("hold_data", int'(reg_write_data), 8'h10);

    // SUB via immediate to zero, then signed SLT back-to-back
    issue(OP_SUB, 5, 8'h33, 5, 1, 1, 7);
    chk("sub_data", int'(reg_write_data), 0);
    chk("sub_zero", int'(zero_flag), 1);
    chk("sub_carry", int'(carry_flag), 0);
    issue(OP_SLT, 8'h80, 1, 0, 0, 1, 4);
    chk("slt_data", int'(reg_write_data), 1);
    issue(OP_SLL, 8'h81, 8'h0B, 0, 0, 1, 8);
    chk("sll_data", int'(reg_write_data), 8'h08);
    issue(OP_NOR, 8'h0F, 8'h30, 0, 0, 1, 9);
    chk("nor_data", int'(reg_write_data), 8'hC0);
    idle(1);

    // Multiply with a second instruction waiting throughout
    issue(OP_MUL, 13, 11, 0, 0, 1, 2);
    alu_op = 4'(OP_OR); reg_read_data_1 = 8'h0F; reg_read_data_2 = 8'h30;
    use_imm = 1'b0; wb_en_in = 1'b1; wb_dest_in = 4'd6; in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("mul_ready_low", int'(in_ready), 0);
      chk("mul_busy", int'(busy), 1);
      chk("mul_no_we", int'(reg_write_en), 0);
      @(posedge clk);
      #1;
    end
    chk("mul_we", int'(reg_write_en), 1);
    chk("mul_data", int'(reg_write_data), 8'h8F);
    chk("mul_dest", int'(reg_write_dest), 2);
    chk("mul_ready_back", int'(in_ready), 1);
    @(posedge clk);
    #1;
    chk("held_or_data", int'(reg_write_data), 8'h3F);
    chk("held_or_dest", int'(reg_write_dest), 6);
    idle(1);

    // Writes to r0 are suppressed; then three ORs back-to-back
    issue(OP_ADD, 1, 1, 0, 0, 1, 0);
    chk("r0_we", int'(reg_write_en), 0);
    chk("r0_zero", int'(zero_flag), 0);
    issue(OP_OR, 1, 2, 0, 0, 1, 1);
    chk("or1_we", int'(reg_write_en), 1);
    chk("or1_data", int'(reg_write_data), 3);
    issue(OP_OR, 4, 8, 0, 0, 1, 2);
    chk("or2_we", int'(reg_write_en), 1);
    chk("or2_dest", int'(reg_write_dest), 2);
    issue(OP_OR, 8'h10, 8'h20, 0, 0, 1, 3);
    chk("or3_we", int'(reg_write_en), 1);
    chk("or3_data", int'(reg_write_data), 8'h30);
    idle(1);

    // Reset in the middle of a multiply
    issue(OP_MUL, 3, 5, 0, 0, 1, 9);
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    model_reset = 1'b1;
    #1;
    chk("arst_ready", int'(in_ready), 1);
    chk("arst_busy", int'(busy), 0);
    chk("arst_data", int'(reg_write_data), 0);
    chk("arst_dest", int'(reg_write_dest), 0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      chk("arst_no_we", int'(reg_write_en), 0);
    end
    chk("arst_ready_after", int'(in_ready), 1);

    // End-to-end through the register file
    issue(OP_PASSB, 0, 0, 8'h55, 1, 1, 5);
    idle(1);
    reg_read_data_1 = rf[5];
    chk("rf_r5", int'(reg_read_data_1), 8'h55);
    issue(OP_ADD, int'(rf[5]), 0, 0, 0, 1, 6);
    chk("rf_add_data", int'(reg_write_data), 8'h55);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
